// File: rtl/pkt_frame_pkg.sv
// Shared types and constants for the multi-channel packet framing checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int ERR_NO_SOP  = 0;
  localparam int ERR_DUP_SOP = 1;
  localparam int ERR_OVERLEN = 2;
  localparam int ERR_TIMEOUT = 3;
  localparam int NERR        = 4;

endpackage

// File: rtl/pkt_frame_chan.sv
// One channel of framing checking: FSM, length/gap tracking, packet counter.
// Latency: done/pkt_len/err registered, one cycle after the sampled beat; err_nxt is the pre-register view.
// Backpressure: none; the block only observes the beat stream.
module pkt_frame_chan
  import pkt_frame_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic             first,
  input  logic             lastbit,
  output logic             done,
  output logic [LEN_W-1:0] pkt_len,
  output logic [NERR-1:0]  err,
  output logic [NERR-1:0]  err_nxt,
  output logic [CNT_W-1:0] cnt
);

  // gap only needs to count up to TIMEOUT; keep one bit when the check is disabled
  localparam int               GAP_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LEN_W:0]   MAXL  = (LEN_W + 1)'(MAX_LEN);
  localparam logic [GAP_W-1:0] TO_V  = GAP_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             done_d;
  logic [LEN_W-1:0] plen_d;
  logic             start;
  logic [LEN_W:0]   nlen;
  logic [GAP_W-1:0] ngap;

  // one extra bit so len+1 can be compared against MAX_LEN without overflow
  assign nlen = {1'b0, len_q} + (LEN_W + 1)'(1);
  assign ngap = gap_q + GAP_W'(1);

  // next-state, length/gap tracking and pre-register output pulses
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    plen_d  = '0;
    err_nxt = '0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (vld) begin
          if (first) start = 1'b1;
          else       err_nxt[ERR_NO_SOP] = 1'b1;
        end
      end
      IN_PKT: begin
        if (vld) begin
          if (first) begin
            // abandon the open packet and restart on this beat
            err_nxt[ERR_DUP_SOP] = 1'b1;
            start = 1'b1;
          end else if (nlen > MAXL) begin
            err_nxt[ERR_OVERLEN] = 1'b1;
            state_d = lastbit ? IDLE : DRAIN;
          end else if (lastbit) begin
            done_d  = 1'b1;
            plen_d  = nlen[LEN_W-1:0];
            state_d = IDLE;
          end else if (nlen == MAXL) begin
            // a plain beat at MAX_LEN leaves no room for the closing beat
            err_nxt[ERR_OVERLEN] = 1'b1;
            state_d = DRAIN;
          end else begin
            len_d = nlen[LEN_W-1:0];
            gap_d = '0;
          end
        end else if ((TIMEOUT != 0) && (ngap == TO_V)) begin
          err_nxt[ERR_TIMEOUT] = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = ngap;
        end
      end
      DRAIN: begin
        if (vld) begin
          if (lastbit)    state_d = IDLE;
          else if (first) start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // common start-of-packet handling shared by IDLE, IN_PKT and DRAIN
    if (start) begin
      len_d = LEN_W'(1);
      gap_d = '0;
      if (lastbit) begin
        done_d  = 1'b1;
        plen_d  = LEN_W'(1);
        state_d = IDLE;
      end else begin
        state_d = IN_PKT;
      end
    end
  end

  // state, tracking registers, registered outputs and packet counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      done    <= 1'b0;
      pkt_len <= '0;
      err     <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      done    <= done_d;
      pkt_len <= plen_d;
      err     <= err_nxt;
      if (done_d) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pkt_frame_chk.sv
// Multi-channel packet framing checker: per-channel error pulses, lengths, counters, sticky errors.
// Latency: all outputs registered one cycle after the sampled beat, except rd_cnt (combinational).
// Backpressure: none; observes the sources without stalling them.
module pkt_frame_chk
  import pkt_frame_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int RD_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       pkt_data_vld,
  input  logic [NCH-1:0]       first,
  input  logic [NCH-1:0]       lastbit,
  output logic [NCH-1:0]       pkt_done,
  output logic [NCH*LEN_W-1:0] pkt_len,
  output logic [NCH*NERR-1:0]  err_vec,
  output logic [NERR-1:0]      err_sticky,
  input  logic                 err_clr,
  input  logic [RD_W-1:0]      rd_ch,
  output logic [CNT_W-1:0]     rd_cnt
);

  logic [NERR-1:0]  ch_err_nxt [NCH];
  logic [CNT_W-1:0] ch_cnt     [NCH];
  logic [NERR-1:0]  err_any;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pkt_frame_chan #(
      .MAX_LEN (MAX_LEN),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W),
      .LEN_W   (LEN_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .vld     (pkt_data_vld[g]),
      .first   (first[g]),
      .lastbit (lastbit[g]),
      .done    (pkt_done[g]),
      .pkt_len (pkt_len[g*LEN_W +: LEN_W]),
      .err     (err_vec[g*NERR +: NERR]),
      .err_nxt (ch_err_nxt[g]),
      .cnt     (ch_cnt[g])
    );
  end

  // OR the not-yet-registered error pulses so sticky rises with err_vec
  always_comb begin
    err_any = '0;
    for (int i = 0; i < NCH; i++) err_any |= ch_err_nxt[i];
  end

  // sticky errors: clear first, then set, so a same-cycle new error survives err_clr
  always_ff @(posedge clk) begin
    if (rst) err_sticky <= '0;
    else     err_sticky <= (err_clr ? '0 : err_sticky) | err_any;
  end

  // counter read mux; any select with no matching channel reads zero
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == RD_W'(i)) rd_cnt = ch_cnt[i];
    end
  end

endmodule

// File: tb/tb_pkt_frame_chk.sv
// Directed bench for pkt_frame_chk with a one-cycle-latency expectation queue.
// dut_a: NCH=4, MAX_LEN=64, TIMEOUT=16, CNT_W=2. dut_b: NCH=3, MAX_LEN=4 for length limits.
// Inputs are shared; sel_b chooses which instance the scoreboard compares.
module tb_pkt_frame_chk;

  typedef struct packed {
    logic [3:0]  done;
    logic [31:0] lens;   // 8 bits per channel
    logic [15:0] err;
    logic [3:0]  sticky;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vld = '0, first = '0, lastbit = '0;
  logic        err_clr = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic        sel_b = 1'b0;

  logic [3:0]  done_a;
  logic [27:0] len_a;
  logic [15:0] err_a;
  logic [3:0]  sticky_a;
  logic [1:0]  rd_cnt_a;

  logic [2:0]  done_b;
  logic [8:0]  len_b;
  logic [11:0] err_b;
  logic [3:0]  sticky_b;
  logic [1:0]  rd_cnt_b;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pkt_frame_chk #(.NCH(4), .MAX_LEN(64), .TIMEOUT(16), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .pkt_data_vld(vld), .first(first), .lastbit(lastbit),
    .pkt_done(done_a), .pkt_len(len_a), .err_vec(err_a), .err_sticky(sticky_a),
    .err_clr(err_clr), .rd_ch(rd_ch), .rd_cnt(rd_cnt_a)
  );

  pkt_frame_chk #(.NCH(3), .MAX_LEN(4), .TIMEOUT(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .pkt_data_vld(vld[2:0]), .first(first[2:0]), .lastbit(lastbit[2:0]),
    .pkt_done(done_b), .pkt_len(len_b), .err_vec(err_b), .err_sticky(sticky_b),
    .err_clr(err_clr), .rd_ch(rd_ch), .rd_cnt(rd_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ex(input logic [3:0] d, input logic [31:0] l,
                              input logic [15:0] e, input logic [3:0] s);
    exp_t r;
    r.done = d; r.lens = l; r.err = e; r.sticky = s;
    return r;
  endfunction

  task automatic check_out();
    exp_t        e;
    logic [31:0] ol;
    e  = sb_q.pop_front();
    ol = '0;
    for (int c = 0; c < 4; c++) begin
      if (sel_b) begin
        if (c < 3) ol[8*c +: 8] = {5'b0, len_b[3*c +: 3]};
      end else begin
        ol[8*c +: 8] = {1'b0, len_a[7*c +: 7]};
      end
    end
    chk("pkt_done",   {28'b0, (sel_b ? {1'b0, done_b} : done_a)}, {28'b0, e.done});
    chk("err_vec",    {16'b0, (sel_b ? {4'b0, err_b} : err_a)},   {16'b0, e.err});
    chk("err_sticky", {28'b0, (sel_b ? sticky_b : sticky_a)},      {28'b0, e.sticky});
    for (int c = 0; c < 4; c++) begin
      if (e.done[c]) chk($sformatf("pkt_len[%0d]", c), {24'b0, ol[8*c +: 8]}, {24'b0, e.lens[8*c +: 8]});
    end
  endtask

  // drive one cycle of stimulus, queue its expected outcome, compare after the edge
  task automatic step(input logic [3:0] v, input logic [3:0] f, input logic [3:0] l,
                      input logic clr, input exp_t e);
    vld = v; first = f; lastbit = l; err_clr = clr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    vld = '0; first = '0; lastbit = '0; err_clr = 1'b0;
    check_out();
  endtask

  task automatic rdchk(input logic [1:0] ch, input logic [1:0] exp);
    rd_ch = ch;
    #1;
    chk($sformatf("rd_cnt[%0d]", ch), {30'b0, (sel_b ? rd_cnt_b : rd_cnt_a)}, {30'b0, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst pkt_done", {28'b0, done_a}, 32'h0);
    chk("rst pkt_len", {4'b0, len_a}, 32'h0);
    chk("rst err_vec", {16'b0, err_a}, 32'h0);
    chk("rst err_sticky", {28'b0, sticky_a}, 32'h0);
    rdchk(2'd0, 2'd0);
    rst = 1'b0;

    // legal 5-beat packet on ch0
    step(4'h1, 4'h1, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h0));
    for (int i = 0; i < 3; i++) step(4'h1, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h0));
    step(4'h1, 4'h0, 4'h1, 1'b0, ex(4'h1, 32'h5, 16'h0, 4'h0));
    rdchk(2'd0, 2'd1);
    step(4'h0, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h0));

    // ch1: missing start, duplicate start, then close
    step(4'h2, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0010, 4'h1));
    step(4'h0, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0,    4'h1));
    step(4'h2, 4'h2, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0,    4'h1));
    step(4'h2, 4'h2, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0020, 4'h3));
    step(4'h2, 4'h0, 4'h2, 1'b0, ex(4'h2, 32'h0000_0200, 16'h0, 4'h3));
    rdchk(2'd1, 2'd1);

    // ch3: inter-beat timeout after 16 idle cycles, then a beat without start
    step(4'h8, 4'h8, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h3));
    for (int i = 0; i < 16; i++)
      step(4'h0, 4'h0, 4'h0, 1'b0, (i == 15) ? ex(4'h0, 32'h0, 16'h8000, 4'hB)
                                             : ex(4'h0, 32'h0, 16'h0,    4'h3));
    step(4'h8, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h1000, 4'hB));

    // all channels complete single-beat packets together
    step(4'hF, 4'hF, 4'hF, 1'b0, ex(4'hF, 32'h0101_0101, 16'h0, 4'hB));
    rdchk(2'd0, 2'd2);
    rdchk(2'd3, 2'd1);

    // sticky clear alone, then clear racing a new error
    step(4'h0, 4'h0, 4'h0, 1'b1, ex(4'h0, 32'h0, 16'h0,    4'h0));
    step(4'h1, 4'h0, 4'h0, 1'b1, ex(4'h0, 32'h0, 16'h0001, 4'h1));

    // reset in the middle of a packet aborts it silently
    step(4'h1, 4'h1, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h1));
    do_reset();
    chk("mid-rst err_vec", {16'b0, err_a}, 32'h0);
    chk("mid-rst err_sticky", {28'b0, sticky_a}, 32'h0);
    rdchk(2'd0, 2'd0);
    rdchk(2'd1, 2'd0);
    for (int i = 0; i < 17; i++) step(4'h0, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h0));

    // 2-bit counter wraps after four packets
    for (int i = 0; i < 5; i++) begin
      step(4'h1, 4'h1, 4'h1, 1'b0, ex(4'h1, 32'h1, 16'h0, 4'h0));
      rdchk(2'd0, 2'((i + 1) % 4));
    end

    // length limits on dut_b (MAX_LEN=4), ch2
    do_reset();
    sel_b = 1'b1;
    step(4'h4, 4'h4, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h0));
    step(4'h4, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h0));
    step(4'h4, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h0));
    step(4'h4, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0400, 4'h4));
    step(4'h4, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h4));
    step(4'h4, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h4));
    step(4'h4, 4'h0, 4'h4, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h4));
    step(4'h4, 4'h4, 4'h4, 1'b0, ex(4'h4, 32'h0001_0000, 16'h0, 4'h4));
    // a packet of exactly MAX_LEN beats is legal
    step(4'h4, 4'h4, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h4));
    step(4'h4, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h4));
    step(4'h4, 4'h0, 4'h0, 1'b0, ex(4'h0, 32'h0, 16'h0, 4'h4));
    step(4'h4, 4'h0, 4'h4, 1'b0, ex(4'h4, 32'h0004_0000, 16'h0, 4'h4));
    rdchk(2'd2, 2'd2);
    // select beyond the last channel reads zero
    rdchk(2'd3, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
